// File: rtl/sample_ring_ctrl.sv
// sample_ring_ctrl: single-clock output sample ring for the synthesizer.
// Takes mixer samples, releases them at the sample rate to the DAC register
// and an Avalon-ST source, and throttles the generator through o_gen_en.
`timescale 1ns/1ps

module sample_ring_ctrl #(
  parameter int DEPTH  = 16,
  parameter int DW     = 24,
  parameter int CLK_HZ = 50_000_000,
  parameter int FS_HZ  = 96_000,
  parameter int PRIME  = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_smp_valid,
  input  logic [DW-1:0]            i_smp_data,
  input  logic                     i_flush,
  output logic                     o_gen_en,
  output logic                     o_tick,
  output logic [DW-1:0]            o_dac_data,
  output logic [31:0]              aso_data,
  output logic                     aso_valid,
  input  logic                     aso_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_underrun_cnt,
  output logic [15:0]              o_overrun_cnt,
  output logic [15:0]              o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [31:0]     acc;
  logic [32:0]     acc_sum;
  logic            tick;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [DW-1:0]   rd_data;

  logic            pop;
  logic            underrun;
  logic            push_ok;
  logic            push_drop;
  logic            stream_drop;
  logic [LW-1:0]   level_next;

  // Phase accumulator sum; a tick fires whenever the sum reaches CLK_HZ
  always_comb begin
    acc_sum = {1'b0, acc} + 33'(FS_HZ);
    tick    = (acc_sum >= 33'(CLK_HZ));
  end

  // Per-cycle event decode; flush suppresses every ring and stream event
  always_comb begin
    rd_data     = mem[rd_ptr];
    pop         = !i_flush && tick && (state == ST_RUN) && (o_level != '0);
    underrun    = !i_flush && tick && (state == ST_RUN) && (o_level == '0);
    push_ok     = !i_flush && i_smp_valid && ((o_level < LW'(DEPTH)) || pop);
    push_drop   = !i_flush && i_smp_valid && !((o_level < LW'(DEPTH)) || pop);
    stream_drop = pop && aso_valid && !aso_ready;
    level_next  = o_level;
    if (i_flush) begin
      level_next = '0;
    end else if (push_ok && !pop) begin
      level_next = o_level + LW'(1);
    end else if (pop && !push_ok) begin
      level_next = o_level - LW'(1);
    end
  end

  // Next-state logic: priming until enough samples, back to priming on underrun or flush
  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = ST_PRIME;
    end else begin
      case (state)
        ST_PRIME: if (o_level >= LW'(PRIME)) state_next = ST_RUN;
        ST_RUN:   if (underrun) state_next = ST_PRIME;
        default:  state_next = ST_PRIME;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_PRIME;
    end else begin
      state <= state_next;
    end
  end

  // Tick generator: accumulator survives flush, only reset clears it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc    <= '0;
      o_tick <= 1'b0;
    end else begin
      acc    <= tick ? 32'(acc_sum - 33'(CLK_HZ)) : acc_sum[31:0];
      o_tick <= tick;
    end
  end

  // Sample storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_smp_data;
    end
  end

  // Ring pointers, fill level and generator throttle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_level  <= '0;
      o_gen_en <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end
      o_level  <= level_next;
      o_gen_en <= (level_next <= LW'(DEPTH - 2));
    end
  end

  // DAC register and stream beat: a pop loads both, a handshake retires the beat
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_dac_data <= '0;
      aso_data   <= '0;
      aso_valid  <= 1'b0;
    end else if (i_flush) begin
      o_dac_data <= '0;
      aso_valid  <= 1'b0;
    end else if (pop) begin
      o_dac_data <= rd_data;
      aso_data   <= {{(32 - DW){1'b0}}, rd_data};
      aso_valid  <= 1'b1;
    end else if (aso_valid && aso_ready) begin
      aso_valid  <= 1'b0;
    end
  end

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_underrun_cnt <= '0;
      o_overrun_cnt  <= '0;
      o_drop_cnt     <= '0;
    end else begin
      if (underrun && (o_underrun_cnt != 16'hFFFF)) o_underrun_cnt <= o_underrun_cnt + 16'd1;
      if (push_drop && (o_overrun_cnt != 16'hFFFF)) o_overrun_cnt <= o_overrun_cnt + 16'd1;
      if (stream_drop && (o_drop_cnt != 16'hFFFF))  o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sample_ring_ctrl.sv
// tb_sample_ring_ctrl: randomized and directed stimulus for sample_ring_ctrl,
// checked against a queue-based reference model and a stream-beat scoreboard.
`timescale 1ns/1ps

module tb_sample_ring_ctrl;

  localparam int DEPTH  = 8;
  localparam int DW     = 24;
  localparam int CLK_HZ = 960_000;
  localparam int FS_HZ  = 96_000;
  localparam int PRIME  = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          smpValid = 1'b0;
  logic [DW-1:0] smpData = '0;
  logic          smpFlush = 1'b0;
  logic          asoReady = 1'b1;
  logic          genEn;
  logic          tickOut;
  logic [DW-1:0] dacData;
  logic [31:0]   asoData;
  logic          asoValid;
  logic [3:0]    level;
  logic [15:0]   underrunCnt;
  logic [15:0]   overrunCnt;
  logic [15:0]   dropCnt;

  int checks = 0;
  int errors = 0;
  int beatsSeen = 0;

  // Reference model state: the ring is a plain queue, timing comes from arithmetic
  logic [DW-1:0] mRing[$];
  logic [31:0]   expBeats[$];
  longint        mEdges;
  bit            mRunning;
  logic [DW-1:0] mDac;
  bit            mStreamValid;
  logic [31:0]   mStreamData;
  bit            mTick;
  bit            mGenEn;
  int            mUnder;
  int            mOver;
  int            mDrop;

  sample_ring_ctrl #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .CLK_HZ(CLK_HZ),
    .FS_HZ (FS_HZ),
    .PRIME (PRIME)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_smp_valid   (smpValid),
    .i_smp_data    (smpData),
    .i_flush       (smpFlush),
    .o_gen_en      (genEn),
    .o_tick        (tickOut),
    .o_dac_data    (dacData),
    .aso_data      (asoData),
    .aso_valid     (asoValid),
    .aso_ready     (asoReady),
    .o_level       (level),
    .o_underrun_cnt(underrunCnt),
    .o_overrun_cnt (overrunCnt),
    .o_drop_cnt    (dropCnt)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit tickAt(longint n);
    return ((n * FS_HZ) / CLK_HZ) > (((n - 1) * FS_HZ) / CLK_HZ);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRing.delete();
    expBeats.delete();
    mEdges       = 0;
    mRunning     = 0;
    mDac         = '0;
    mStreamValid = 0;
    mStreamData  = '0;
    mTick        = 0;
    mGenEn       = 0;
    mUnder       = 0;
    mOver        = 0;
    mDrop        = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT just sampled
  task automatic modelStep();
    int            lvl0;
    bit            tk;
    bit            doPop;
    bit            under;
    logic [DW-1:0] v;
    logic [31:0]   beat;
    if (!n_rst) return;
    lvl0   = mRing.size();
    mEdges = mEdges + 1;
    tk     = tickAt(mEdges);
    mTick  = tk;
    if (smpFlush) begin
      if (mStreamValid && !asoReady) void'(expBeats.pop_back());
      mRing.delete();
      mRunning     = 0;
      mStreamValid = 0;
      mDac         = '0;
    end else begin
      doPop = tk && mRunning && (lvl0 > 0);
      under = tk && mRunning && (lvl0 == 0);
      if (doPop) begin
        v    = mRing.pop_front();
        mDac = v;
        beat = {8'h00, v};
        if (mStreamValid && !asoReady) begin
          void'(expBeats.pop_back());
          if (mDrop < 65535) mDrop++;
        end
        expBeats.push_back(beat);
        mStreamValid = 1;
        mStreamData  = beat;
      end else if (mStreamValid && asoReady) begin
        mStreamValid = 0;
      end
      if (smpValid) begin
        if ((lvl0 < DEPTH) || doPop) mRing.push_back(smpData);
        else if (mOver < 65535) mOver++;
      end
      if (under) begin
        mRunning = 0;
        if (mUnder < 65535) mUnder++;
      end else if (!mRunning && (lvl0 >= PRIME)) begin
        mRunning = 1;
      end
    end
    mGenEn = (mRing.size() <= DEPTH - 2);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
    smpValid = v;
    smpData  = d;
    smpFlush = f;
    asoReady = r;
    @(posedge clk);
    modelStep();
    #2;
  endtask

  // Monitor: compares registered outputs to the model and retires stream beats
  always @(negedge clk) begin
    logic [31:0] exp;
    checkOutput("level", 32'(level), 32'(mRing.size()));
    checkOutput("dac_data", 32'(dacData), 32'(mDac));
    checkOutput("tick", 32'(tickOut), 32'(mTick));
    checkOutput("gen_en", 32'(genEn), 32'(mGenEn));
    checkOutput("aso_valid", 32'(asoValid), 32'(mStreamValid));
    checkOutput("underrun_cnt", 32'(underrunCnt), 32'(mUnder));
    checkOutput("overrun_cnt", 32'(overrunCnt), 32'(mOver));
    checkOutput("drop_cnt", 32'(dropCnt), 32'(mDrop));
    checks++;
    if (level > 4'd8) begin
      errors++;
      $display("[TB] FAIL level_bound actual=%0d required<=8", level);
    end
    if (asoValid) checkOutput("aso_data_held", asoData, mStreamData);
    if (asoValid && asoReady) begin
      if (expBeats.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_unexpected actual=%h required=none", asoData);
      end else begin
        exp = expBeats.pop_front();
        checkOutput("aso_beat", asoData, exp);
        beatsSeen++;
      end
    end
  end

  initial begin
    int snapUnder;
    int snapOver;
    int snapDrop;
    bit hit;
    modelReset();
    n_rst = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("rst_gen_en", 32'(genEn), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_aso_valid", 32'(asoValid), 32'h0);
    checkOutput("rst_dac", 32'(dacData), 32'h0);
    n_rst = 1'b1;

    // Priming and three in-order samples, ending in an underrun
    applyStimulus(0, '0, 0, 1);
    checkOutput("gen_en_after_reset", 32'(genEn), 32'h1);
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(1, DW'(s), 0, 1);
      applyStimulus(0, '0, 0, 1);
      applyStimulus(0, '0, 0, 1);
    end
    for (int i = 0; i < 39; i++) applyStimulus(0, '0, 0, 1);
    checkOutput("s1_beats", 32'(beatsSeen), 32'd3);
    checkOutput("s1_dac_last", 32'(dacData), 32'h3);
    checkOutput("s1_underrun", 32'(underrunCnt), 32'd1);

    // Push every cycle regardless of the throttle
    for (int i = 0; i < 14; i++) applyStimulus(1, DW'($urandom), 0, 1);

    // Stream stalled while running
    for (int i = 0; i < 25; i++) applyStimulus((i % 3) == 0, DW'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 1);

    // Extreme signed values must stay zero-extended on the stream
    applyStimulus(1, 24'h800000, 0, 1);
    applyStimulus(1, 24'h7FFFFF, 0, 1);
    for (int i = 0; i < 40; i++) applyStimulus(0, '0, 0, 1);

    // Flush coincident with a push and a tick at level 5
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if ((mRing.size() == 5) && tickAt(mEdges + 1)) begin
        snapUnder = mUnder;
        snapOver  = mOver;
        snapDrop  = mDrop;
        applyStimulus(1, DW'($urandom), 1, 1);
        hit = 1;
      end else begin
        applyStimulus(mRing.size() < 5, DW'($urandom), 0, 1);
      end
    end
    checkOutput("flush_aligned", 32'(hit), 32'h1);
    if (hit) begin
      checkOutput("flush_level", 32'(level), 32'h0);
      checkOutput("flush_aso_valid", 32'(asoValid), 32'h0);
      checkOutput("flush_dac", 32'(dacData), 32'h0);
      checkOutput("flush_underrun", 32'(underrunCnt), 32'(snapUnder));
      checkOutput("flush_overrun", 32'(overrunCnt), 32'(snapOver));
      checkOutput("flush_drop", 32'(dropCnt), 32'(snapDrop));
    end

    // Reset in the middle of running
    for (int i = 0; i < 25; i++) applyStimulus((i % 2) == 0, DW'($urandom), 0, (i % 4) != 0);
    n_rst = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_level", 32'(level), 32'h0);
    checkOutput("midrst_dac", 32'(dacData), 32'h0);
    checkOutput("midrst_aso", 32'(asoData), 32'h0);
    checkOutput("midrst_valid", 32'(asoValid), 32'h0);
    checkOutput("midrst_gen_en", 32'(genEn), 32'h0);
    checkOutput("midrst_tick", 32'(tickOut), 32'h0);
    checkOutput("midrst_counters", {underrunCnt, overrunCnt | dropCnt}, 32'h0);
    #1;
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 1);
    n_rst = 1'b1;

    // Randomized traffic with bursts, stalls and occasional flushes
    for (int i = 0; i < 2000; i++) begin
      logic v;
      logic f;
      logic r;
      v = ((i % 200) < 20) ? 1'b1 : ($urandom_range(0, 9) < 4);
      f = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 9) < 7);
      applyStimulus(v, DW'($urandom), f, r);
    end
    for (int i = 0; i < 30; i++) applyStimulus(0, '0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
